fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; successor to the fixed 8-bit sync FIFO.
- Configurable width, depth and almost-full/almost-empty thresholds.
- Adds an occupancy count, single-cycle overflow/underflow error pulses, and a first-word-fall-through (FWFT) mode.
- Used as the standard buffering element between producer/consumer blocks in the same clock domain.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries (>=2, need not be a power of 2).
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, 0 = registered-read mode; 1 = first-word-fall-through mode.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- write  in  1  write request
- read  in  1  read request
- data_in  in  WIDTH  write data
- data_out  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  AW+1  occupancy 0..DEPTH, where AW = clog2(DEPTH)
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset is asynchronous assert and synchronous release (reset_n low):
  - wr_ptr = rd_ptr = 0, count = 0, data_out = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0 (for AF_LEVEL >= 1).
  - Storage array is not reset; contents are discarded.
  - Reset mid-operation drops all stored words.
- Acceptance, evaluated at each rising edge:
  - rd_acc = read & ~empty.
  - wr_acc = write & (~full | rd_acc). A write while full is accepted when a read pops in the same cycle.
- An accepted write stores data_in at mem[wr_ptr]; wr_ptr increments and wraps from DEPTH-1 to 0.
- An accepted read advances rd_ptr with the same wrap rule.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur.
- Status outputs:
  - full, empty, almost_full and almost_empty decode combinationally from the registered count.
  - They change only after a clock edge, never combinationally from inputs.
- Error pulses, registered and high for exactly one cycle after the offending edge:
  - overflow = write & ~wr_acc.
  - underflow = read & ~rd_acc.
  - An empty FIFO with simultaneous read and write gives a write accept, a read reject, underflow = 1 and count -> 1.
- FWFT = 0 (registered read):
  - On rd_acc, data_out <= mem[rd_ptr] at that edge, so read latency is 1 cycle.
  - data_out holds its value when no read is accepted.
- FWFT = 1 (fall-through):
  - data_out = mem[rd_ptr] combinationally; it is valid whenever empty = 0.
  - read acts as a pop/acknowledge.
  - A word written at edge N is visible on data_out after edge N, in the same cycle empty falls.
  - When empty = 1, data_out is don't-care; the bench must not check it.
- Ordering is strict FIFO; no word is lost or duplicated across pointer wrap.
- Parameter checks at elaboration: AF_LEVEL in 1..DEPTH, AE_LEVEL in 0..DEPTH-1; fatal error otherwise.

Decomposition:
- Package fifo_pkg holds:
  - the clog2 function;
  - default WIDTH/DEPTH constants;
  - mode constants FIFO_MODE_REG = 0 and FIFO_MODE_FWFT = 1.
- Sub-module fifo_mem: WIDTH x DEPTH register array with one synchronous write port and one asynchronous read port (address = rd_ptr).
- Pointer, count, flag and output-register logic stay in fifo_sync_param.

Test Plan (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1 unless noted):
- Reset, then write 0xA1,0xB2,0xC3 on 3 edges -> count 1,2,3; almost_empty falls after edge 2; almost_full rises after edge 3; full = 0.
- Continue with write 0xD4, then write 0xE5 while full -> full = 1, count = 4; overflow pulses 1 cycle; 0xE5 is not stored.
- FWFT=0: read 4 times -> data_out 0xA1,0xB2,0xC3,0xD4, each valid 1 cycle after its read edge; then read while empty -> underflow pulse, data_out holds 0xD4.
- While full, assert write=1 with data_in 0x55 and read=1 simultaneously -> both accepted, count stays 4; after 6 total writes/reads the pointers have wrapped and the order is preserved.
- FWFT=1: write 0x7E into an empty FIFO -> data_out = 0x7E and empty = 0 right after that edge; read -> empty = 1 next cycle.
- With count = 3, drive reset_n low mid-cycle -> all outputs return to reset values immediately (asynchronously), before the next edge; after release a read gives underflow = 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO family.
package fifo_pkg;

    localparam int unsigned FIFO_DEF_WIDTH = 8;
    localparam int unsigned FIFO_DEF_DEPTH = 16;

    localparam int unsigned FIFO_MODE_REG  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer-facing bundle of the synchronous FIFO.
interface fifo_sync_param_if import fifo_pkg::*; #(
    parameter int unsigned WIDTH = FIFO_DEF_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEF_DEPTH
);
    localparam int unsigned CW = clog2(DEPTH) + 1;

    logic             write;
    logic             read;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output write, read, data_in,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  write, read, data_in,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module fifo_mem import fifo_pkg::*; #(
    parameter int unsigned WIDTH = FIFO_DEF_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEF_DEPTH,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parameterised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and optional first-word-fall-through read.
module fifo_sync_param import fifo_pkg::*; #(
    parameter int unsigned WIDTH    = FIFO_DEF_WIDTH,
    parameter int unsigned DEPTH    = FIFO_DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1,
    parameter int unsigned FWFT     = FIFO_MODE_REG
) (
    input  logic             clk,
    input  logic             reset_n,
    fifo_sync_param_if.slave bus
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Reject configurations whose thresholds can never be meaningful.
    if (WIDTH < 1 || DEPTH < 2) begin : g_bad_size
        $fatal(1, "fifo_sync_param: WIDTH must be >= 1 and DEPTH >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $fatal(1, "fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $fatal(1, "fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             empty_c;
    logic             full_c;
    logic             rd_acc_c;
    logic             wr_acc_c;
    logic [WIDTH-1:0] rd_data_c;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_c  = (count_q == '0);
    assign full_c   = (count_q == CW'(DEPTH));
    assign rd_acc_c = bus.read & ~empty_c;
    assign wr_acc_c = bus.write & (~full_c | rd_acc_c);

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en     (wr_acc_c),
        .wr_addr   (wr_ptr),
        .wr_data   (bus.data_in),
        .rd_addr   (rd_ptr),
        .rd_data_c (rd_data_c)
    );

    // Pointers, occupancy and error pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            overflow_q  <= bus.write & ~wr_acc_c;
            underflow_q <= bus.read & ~rd_acc_c;
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign bus.data_out = rd_data_c;
    end else begin : g_reg
        logic [WIDTH-1:0] data_q;

        // Output register loads only on an accepted pop.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
            end else if (rd_acc_c) begin
                data_q <= rd_data_c;
            end
        end

        assign bus.data_out = data_q;
    end

    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: registered-read and FWFT instances, DEPTH=4.
module tb_fifo_sync_param;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.WIDTH(8), .DEPTH(4)) bus_r ();
    fifo_sync_param_if #(.WIDTH(8), .DEPTH(4)) bus_f ();

    fifo_sync_param #(
        .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)
    ) u_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_r)
    );

    fifo_sync_param #(
        .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)
    ) u_fwft (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_f)
    );

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_r(input logic w, input logic r, input logic [7:0] d);
        bus_r.write   = w;
        bus_r.read    = r;
        bus_r.data_in = d;
    endtask

    task automatic drive_f(input logic w, input logic r, input logic [7:0] d);
        bus_f.write   = w;
        bus_f.read    = r;
        bus_f.data_in = d;
    endtask

    task automatic test_reset();
        drive_r(1'b0, 1'b0, 8'h00);
        drive_f(1'b0, 1'b0, 8'h00);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++; if (bus_r.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus_r.count); end
        n_checks++; if ({bus_r.empty, bus_r.full, bus_r.almost_empty, bus_r.almost_full} !== 4'b1010) begin
            n_fail++; $display("FAIL reset_flags got e/f/ae/af=%b exp 1010", {bus_r.empty, bus_r.full, bus_r.almost_empty, bus_r.almost_full}); end
        n_checks++; if (bus_r.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", bus_r.data_out); end
        n_checks++; if ({bus_r.overflow, bus_r.underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b exp 00", {bus_r.overflow, bus_r.underflow}); end
        n_checks++; if ({bus_f.empty, bus_f.count} !== 4'b1_000) begin n_fail++; $display("FAIL reset_fwft got empty=%b count=%0d exp 1/0", bus_f.empty, bus_f.count); end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] wdata [5];
        logic [2:0] exp_cnt [5];
        logic [3:0] exp_flg [5];
        wdata   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        // {empty, full, almost_empty, almost_full}
        exp_flg = '{4'b0010, 4'b0000, 4'b0001, 4'b0101, 4'b0101};
        for (int i = 0; i < 5; i++) begin
            drive_r(1'b1, 1'b0, wdata[i]);
            tick();
            n_checks++; if (bus_r.count !== exp_cnt[i]) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus_r.count, exp_cnt[i]); end
            n_checks++; if ({bus_r.empty, bus_r.full, bus_r.almost_empty, bus_r.almost_full} !== exp_flg[i]) begin
                n_fail++; $display("FAIL fill_flags[%0d] got %b exp %b", i, {bus_r.empty, bus_r.full, bus_r.almost_empty, bus_r.almost_full}, exp_flg[i]); end
            n_checks++; if (bus_r.overflow !== (i == 4)) begin n_fail++; $display("FAIL fill_ovf[%0d] got %b exp %b", i, bus_r.overflow, (i == 4)); end
        end
        drive_r(1'b0, 1'b0, 8'h00);
        tick();
        n_checks++; if (bus_r.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_width got %b exp 0", bus_r.overflow); end
    endtask

    task automatic test_read_underflow();
        logic [7:0] exp_d [4];
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            drive_r(1'b0, 1'b1, 8'h00);
            tick();
            n_checks++; if (bus_r.data_out !== exp_d[i]) begin n_fail++; $display("FAIL read_data[%0d] got %h exp %h", i, bus_r.data_out, exp_d[i]); end
            n_checks++; if (bus_r.count !== 3'(3 - i)) begin n_fail++; $display("FAIL read_count[%0d] got %0d exp %0d", i, bus_r.count, 3 - i); end
        end
        tick();
        n_checks++; if (bus_r.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_pulse got %b exp 1", bus_r.underflow); end
        n_checks++; if (bus_r.data_out !== 8'hD4) begin n_fail++; $display("FAIL udf_hold got %h exp d4", bus_r.data_out); end
        n_checks++; if (bus_r.empty !== 1'b1) begin n_fail++; $display("FAIL udf_empty got %b exp 1", bus_r.empty); end
        drive_r(1'b0, 1'b0, 8'h00);
        tick();
        n_checks++; if (bus_r.underflow !== 1'b0) begin n_fail++; $display("FAIL udf_pulse_width got %b exp 0", bus_r.underflow); end
    endtask

    task automatic test_back_to_back_wrap();
        logic [7:0] exp_d [6];
        exp_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h55, 8'h66};
        for (int i = 0; i < 4; i++) begin
            drive_r(1'b1, 1'b0, 8'(i + 1));
            tick();
        end
        n_checks++; if (bus_r.full !== 1'b1) begin n_fail++; $display("FAIL b2b_full got %b exp 1", bus_r.full); end
        // Push and pop together while full.
        drive_r(1'b1, 1'b1, 8'h55);
        tick();
        n_checks++; if ({bus_r.count, bus_r.overflow} !== 4'b100_0) begin n_fail++; $display("FAIL b2b_count0 got count=%0d ovf=%b exp 4/0", bus_r.count, bus_r.overflow); end
        n_checks++; if (bus_r.data_out !== exp_d[0]) begin n_fail++; $display("FAIL b2b_data0 got %h exp %h", bus_r.data_out, exp_d[0]); end
        drive_r(1'b1, 1'b1, 8'h66);
        tick();
        n_checks++; if (bus_r.count !== 3'd4) begin n_fail++; $display("FAIL b2b_count1 got %0d exp 4", bus_r.count); end
        n_checks++; if (bus_r.data_out !== exp_d[1]) begin n_fail++; $display("FAIL b2b_data1 got %h exp %h", bus_r.data_out, exp_d[1]); end
        for (int i = 2; i < 6; i++) begin
            drive_r(1'b0, 1'b1, 8'h00);
            tick();
            n_checks++; if (bus_r.data_out !== exp_d[i]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h exp %h", i, bus_r.data_out, exp_d[i]); end
        end
        n_checks++; if (bus_r.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b exp 1", bus_r.empty); end
        // Simultaneous read and write on empty: write taken, read rejected.
        drive_r(1'b1, 1'b1, 8'h77);
        tick();
        n_checks++; if ({bus_r.count, bus_r.underflow, bus_r.overflow} !== 5'b001_10) begin
            n_fail++; $display("FAIL empty_rw got count=%0d udf=%b ovf=%b exp 1/1/0", bus_r.count, bus_r.underflow, bus_r.overflow); end
        n_checks++; if (bus_r.data_out !== 8'h66) begin n_fail++; $display("FAIL empty_rw_hold got %h exp 66", bus_r.data_out); end
        drive_r(1'b0, 1'b1, 8'h00);
        tick();
        n_checks++; if ({bus_r.data_out, bus_r.count, bus_r.underflow} !== {8'h77, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL empty_rw_pop got data=%h count=%0d udf=%b exp 77/0/0", bus_r.data_out, bus_r.count, bus_r.underflow); end
        drive_r(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_fwft();
        drive_f(1'b1, 1'b0, 8'h7E);
        tick();
        n_checks++; if ({bus_f.empty, bus_f.count} !== 4'b0_001) begin n_fail++; $display("FAIL fwft_empty got empty=%b count=%0d exp 0/1", bus_f.empty, bus_f.count); end
        n_checks++; if (bus_f.data_out !== 8'h7E) begin n_fail++; $display("FAIL fwft_data got %h exp 7e", bus_f.data_out); end
        drive_f(1'b0, 1'b1, 8'h00);
        tick();
        n_checks++; if ({bus_f.empty, bus_f.underflow} !== 2'b10) begin n_fail++; $display("FAIL fwft_pop got empty=%b udf=%b exp 1/0", bus_f.empty, bus_f.underflow); end
        drive_f(1'b1, 1'b0, 8'h11);
        tick();
        drive_f(1'b1, 1'b0, 8'h22);
        tick();
        drive_f(1'b0, 1'b0, 8'h00);
        n_checks++; if (bus_f.data_out !== 8'h11) begin n_fail++; $display("FAIL fwft_head got %h exp 11", bus_f.data_out); end
        drive_f(1'b0, 1'b1, 8'h00);
        tick();
        n_checks++; if ({bus_f.data_out, bus_f.count} !== {8'h22, 3'd1}) begin n_fail++; $display("FAIL fwft_next got data=%h count=%0d exp 22/1", bus_f.data_out, bus_f.count); end
        tick();
        n_checks++; if (bus_f.empty !== 1'b1) begin n_fail++; $display("FAIL fwft_drain got %b exp 1", bus_f.empty); end
        drive_f(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive_r(1'b1, 1'b0, 8'(8'hC0 + i));
            tick();
        end
        drive_r(1'b0, 1'b0, 8'h00);
        n_checks++; if (bus_r.count !== 3'd3) begin n_fail++; $display("FAIL arst_pre_count got %0d exp 3", bus_r.count); end
        #3 reset_n = 1'b0;
        #1;
        n_checks++; if ({bus_r.count, bus_r.empty, bus_r.almost_empty, bus_r.almost_full, bus_r.full} !== 7'b000_1100) begin
            n_fail++; $display("FAIL arst_flags got count=%0d e/ae/af/f=%b exp 0/1100", bus_r.count, {bus_r.empty, bus_r.almost_empty, bus_r.almost_full, bus_r.full}); end
        n_checks++; if (bus_r.data_out !== 8'h00) begin n_fail++; $display("FAIL arst_dout got %h exp 00", bus_r.data_out); end
        #2 reset_n = 1'b1;
        drive_r(1'b0, 1'b1, 8'h00);
        tick();
        n_checks++; if ({bus_r.underflow, bus_r.count} !== 4'b1_000) begin n_fail++; $display("FAIL arst_udf got udf=%b count=%0d exp 1/0", bus_r.underflow, bus_r.count); end
        drive_r(1'b0, 1'b0, 8'h00);
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_read_underflow();
        test_back_to_back_wrap();
        test_fwft();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
